weight_mem_banked: RTL

WEIGHT_MEM_BANKED -- requirements
Module: weight_mem_banked

---
 rtl/ff_pkg.sv | 20 ++
 rtl/weight_bank.sv | 32 +++
 rtl/weight_mem_banked.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/ff_pkg.sv
// Shared definitions for the banked weight memory: Q16.16 format constants,
// update-mode encoding and control FSM states.
package ff_pkg;

  localparam int unsigned Q_FRAC_BITS = 16;
  localparam logic [31:0] WMAX        = 32'h7FFF_FFFF;
  localparam logic [31:0] WMIN        = 32'h8000_0000;

  typedef enum logic {
    UPD_OVERWRITE = 1'b0,
    UPD_ACCUM     = 1'b1
  } upd_mode_e;

  typedef enum logic [1:0] {
    CLEAR  = 2'd0,
    READY  = 2'd1,
    ACC_WR = 2'd2
  } wm_state_e;

endpackage

// File: rtl/weight_bank.sv
// One-clock true dual-port weight bank: port A read-only, port B read/write
// with read-first behaviour. Contents are not reset.
module weight_bank #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk,
  input  logic                  a_en,
  input  logic [AW-1:0]         a_addr,
  output logic [DATA_WIDTH-1:0] a_dout,
  input  logic                  b_en,
  input  logic                  b_we,
  input  logic [AW-1:0]         b_addr,
  input  logic [DATA_WIDTH-1:0] b_din,
  output logic [DATA_WIDTH-1:0] b_dout
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (a_en) a_dout <= mem[a_addr];
  end

  always_ff @(posedge clk) begin
    if (b_en) begin
      b_dout <= mem[b_addr];
      if (b_we) mem[b_addr] <= b_din;
    end
  end

endmodule

// File: rtl/weight_mem_banked.sv
// Banked weight store: NUM_BANKS parallel read lanes per group plus an update
// port supporting overwrite and saturating accumulate, with a zero sweep.
module weight_mem_banked
  import ff_pkg::*;
#(
  parameter int unsigned NUM_NEURONS = 256,
  parameter int unsigned INPUT_SIZE  = 784,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned NUM_BANKS   = 8
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    clr_req,
  output logic                                    init_done,
  input  logic                                    rd_en,
  input  logic [$clog2(NUM_NEURONS/NUM_BANKS)-1:0] rd_group,
  input  logic [$clog2(INPUT_SIZE)-1:0]            rd_widx,
  output logic                                    rd_valid,
  output logic [NUM_BANKS*DATA_WIDTH-1:0]         rd_data,
  input  logic                                    upd_valid,
  output logic                                    upd_ready,
  input  logic                                    upd_mode,
  input  logic [$clog2(NUM_NEURONS)-1:0]          upd_neuron,
  input  logic [$clog2(INPUT_SIZE)-1:0]           upd_widx,
  input  logic [DATA_WIDTH-1:0]                   upd_data
);

  localparam int unsigned NUM_GROUPS = NUM_NEURONS / NUM_BANKS;
  localparam int unsigned DEPTH      = NUM_GROUPS * INPUT_SIZE;
  localparam int unsigned AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned BW         = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam logic [DATA_WIDTH-1:0] SAT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] SAT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  function automatic logic [DATA_WIDTH-1:0] sat_add(input logic [DATA_WIDTH-1:0] a,
                                                    input logic [DATA_WIDTH-1:0] d);
    logic [DATA_WIDTH:0] s;
    s = {a[DATA_WIDTH-1], a} + {d[DATA_WIDTH-1], d};
    if (s[DATA_WIDTH] != s[DATA_WIDTH-1]) return s[DATA_WIDTH] ? SAT_MIN : SAT_MAX;
    return s[DATA_WIDTH-1:0];
  endfunction

  wm_state_e             state, state_nxt;
  logic [AW-1:0]         clr_cnt;
  logic                  clr_last;

  logic                  rd_ok, rd_fire, rd_ok_q;
  logic [AW-1:0]         rd_addr;

  logic                  upd_ok, upd_fire, upd_is_acc;
  logic [BW-1:0]         upd_bank;
  logic [AW-1:0]         upd_addr;

  logic                  acc_ok;
  logic [BW-1:0]         acc_bank;
  logic [AW-1:0]         acc_addr;
  logic [DATA_WIDTH-1:0] acc_delta;

  logic [NUM_BANKS-1:0]  b_en, b_we;
  logic [AW-1:0]         b_addr [NUM_BANKS];
  logic [DATA_WIDTH-1:0] b_din  [NUM_BANKS];
  logic [DATA_WIDTH-1:0] b_dout [NUM_BANKS];
  logic [DATA_WIDTH-1:0] a_dout [NUM_BANKS];

  assign clr_last   = (clr_cnt == AW'(DEPTH - 1));

  assign rd_ok      = (32'(rd_group) < NUM_GROUPS) && (32'(rd_widx) < INPUT_SIZE);
  assign rd_addr    = AW'(32'(rd_group) * INPUT_SIZE + 32'(rd_widx));
  assign rd_fire    = rd_en && init_done;

  assign upd_ok     = (32'(upd_neuron) < NUM_NEURONS) && (32'(upd_widx) < INPUT_SIZE);
  assign upd_bank   = BW'(32'(upd_neuron) % NUM_BANKS);
  assign upd_addr   = AW'((32'(upd_neuron) / NUM_BANKS) * INPUT_SIZE + 32'(upd_widx));
  assign upd_is_acc = (upd_mode_e'(upd_mode) == UPD_ACCUM);
  assign upd_fire   = upd_valid && upd_ready;

  always_comb begin
    state_nxt = state;
    init_done = (state != CLEAR);
    upd_ready = (state == READY);
    case (state)
      CLEAR:   if (clr_last) state_nxt = READY;
      READY: begin
        if (clr_req)                       state_nxt = CLEAR;
        else if (upd_fire && upd_is_acc)   state_nxt = ACC_WR;
      end
      ACC_WR:  state_nxt = clr_req ? CLEAR : READY;
      default: state_nxt = CLEAR;
    endcase
  end

  // Port B serves the sweep, the update write, or the accumulate read-modify-write.
  always_comb begin
    for (int unsigned b = 0; b < NUM_BANKS; b++) begin
      b_en[b]   = 1'b0;
      b_we[b]   = 1'b0;
      b_addr[b] = clr_cnt;
      b_din[b]  = '0;
    end
    case (state)
      CLEAR: begin
        b_en = '1;
        b_we = '1;
      end
      READY: begin
        if (upd_fire && upd_ok) begin
          b_en[upd_bank]   = 1'b1;
          b_we[upd_bank]   = !upd_is_acc;
          b_addr[upd_bank] = upd_addr;
          b_din[upd_bank]  = upd_data;
        end
      end
      ACC_WR: begin
        if (acc_ok) begin
          b_en[acc_bank]   = 1'b1;
          b_we[acc_bank]   = 1'b1;
          b_addr[acc_bank] = acc_addr;
          b_din[acc_bank]  = sat_add(b_dout[acc_bank], acc_delta);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= CLEAR;
      clr_cnt   <= '0;
      rd_valid  <= 1'b0;
      rd_ok_q   <= 1'b0;
      acc_ok    <= 1'b0;
      acc_bank  <= '0;
      acc_addr  <= '0;
      acc_delta <= '0;
    end else begin
      state    <= state_nxt;
      clr_cnt  <= (state == CLEAR && !clr_last) ? clr_cnt + 1'b1 : '0;
      rd_valid <= rd_fire;
      rd_ok_q  <= rd_fire && rd_ok;
      if (state == READY && upd_fire && upd_is_acc) begin
        acc_ok    <= upd_ok;
        acc_bank  <= upd_bank;
        acc_addr  <= upd_addr;
        acc_delta <= upd_data;
      end
    end
  end

  always_comb begin
    rd_data = '0;
    if (rd_ok_q) begin
      for (int unsigned b = 0; b < NUM_BANKS; b++) rd_data[b*DATA_WIDTH +: DATA_WIDTH] = a_dout[b];
    end
  end

  for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
    weight_bank #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .AW         (AW)
    ) u_bank (
      .clk    (clk),
      .a_en   (rd_fire && rd_ok),
      .a_addr (rd_addr),
      .a_dout (a_dout[g]),
      .b_en   (b_en[g]),
      .b_we   (b_we[g]),
      .b_addr (b_addr[g]),
      .b_din  (b_din[g]),
      .b_dout (b_dout[g])
    );
  end

endmodule
